// File: rtl/everloop_dbuf_ram.sv
// Double-buffered RAM: port a writes the back bank with optional byte reversal,
// port b reads the front bank, swaps land on frame boundaries with optional back-fill copy.
module everloop_dbuf_ram #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 16,
  parameter int SWAP_MODE    = 1,
  parameter int COPY_ON_SWAP = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we_a,
  input  logic [DATA_WIDTH/8-1:0] sel_a,
  input  logic [ADDR_WIDTH-1:0]   adr_a,
  input  logic [DATA_WIDTH-1:0]   dat_a,
  output logic                    ack_a,
  output logic                    busy_a,
  input  logic                    commit,
  input  logic                    frame_done_b,
  input  logic [ADDR_WIDTH-1:0]   adr_b,
  output logic [DATA_WIDTH-1:0]   dat_b,
  output logic                    swap_pending,
  output logic                    front_bank
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [2][DEPTH];

  logic                  accept;
  logic                  do_swap;
  logic                  do_rev;
  logic                  copy_rd;
  logic                  copy_wr;
  logic                  back_bank;
  logic [DATA_WIDTH-1:0] wr_dat;
  logic [NB-1:0]         wr_sel;
  logic [ADDR_WIDTH:0]   cnt;
  logic [ADDR_WIDTH-1:0] copy_wa;
  logic [DATA_WIDTH-1:0] copy_q;

  function automatic logic [DATA_WIDTH-1:0] rev_data(input logic [DATA_WIDTH-1:0] d);
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < NB; i++) r[8*i +: 8] = d[8*(NB-1-i) +: 8];
    return r;
  endfunction

  function automatic logic [NB-1:0] rev_sel(input logic [NB-1:0] s);
    logic [NB-1:0] r;
    r = '0;
    for (int i = 0; i < NB; i++) r[i] = s[NB-1-i];
    return r;
  endfunction

  // Request decode: acceptance, swap condition, lane reversal and copy pipeline strobes
  always_comb begin
    back_bank = ~front_bank;
    accept    = we_a & ~busy_a & ~ack_a;
    do_swap   = frame_done_b & (swap_pending | commit) & ~busy_a;
    do_rev    = (SWAP_MODE == 2) || ((SWAP_MODE == 1) && (adr_a[0] == 1'b0));
    if (do_rev) begin
      wr_dat = rev_data(dat_a);
      wr_sel = rev_sel(sel_a);
    end else begin
      wr_dat = dat_a;
      wr_sel = sel_a;
    end
    // cnt walks 0..DEPTH: reads happen on 0..DEPTH-1, writes trail by one on 1..DEPTH
    copy_rd = busy_a & ~cnt[ADDR_WIDTH];
    copy_wr = busy_a & (cnt != '0);
    copy_wa = cnt[ADDR_WIDTH-1:0] - {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  end

  // Control state: handshake, bank select, pending swap, copy engine, read port
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_a        <= 1'b0;
      busy_a       <= 1'b0;
      swap_pending <= 1'b0;
      front_bank   <= 1'b0;
      dat_b        <= '0;
      cnt          <= '0;
      copy_q       <= '0;
    end else begin
      ack_a <= accept;
      dat_b <= mem[front_bank][adr_b];
      if (copy_rd) begin
        copy_q <= mem[front_bank][cnt[ADDR_WIDTH-1:0]];
      end else begin
        copy_q <= copy_q;
      end
      if (busy_a) begin
        cnt <= cnt + {{ADDR_WIDTH{1'b0}}, 1'b1};
        if (cnt[ADDR_WIDTH]) busy_a <= 1'b0;
      end
      if (do_swap) begin
        front_bank   <= ~front_bank;
        swap_pending <= 1'b0;
        busy_a       <= (COPY_ON_SWAP != 0);
        cnt          <= '0;
      end else if (commit) begin
        swap_pending <= 1'b1;
      end
    end
  end

  // Bank storage: port a byte-lane writes and copy-engine writes, both into the back bank
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (accept) begin
        for (int i = 0; i < NB; i++) begin
          if (wr_sel[i]) mem[back_bank][adr_a][8*i +: 8] <= wr_dat[8*i +: 8];
        end
      end
      if (copy_wr) mem[back_bank][copy_wa] <= copy_q;
    end
  end

endmodule

// File: tb/tb_everloop_dbuf_ram.sv
// Self-checking bench: directed scenarios with literal expectations, then random
// traffic compared every cycle against a behavioural bank model.
module tb_everloop_dbuf_ram;

  localparam int AW    = 8;
  localparam int DW    = 16;
  localparam int NB    = DW / 8;
  localparam int DEPTH = 2 ** AW;
  localparam int SWAP_MODE = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          we_a = 1'b0;
  logic [NB-1:0] sel_a = '0;
  logic [AW-1:0] adr_a = '0;
  logic [DW-1:0] dat_a = '0;
  logic          ack_a;
  logic          busy_a;
  logic          commit = 1'b0;
  logic          frame_done_b = 1'b0;
  logic [AW-1:0] adr_b = '0;
  logic [DW-1:0] dat_b;
  logic          swap_pending;
  logic          front_bank;

  everloop_dbuf_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SWAP_MODE(SWAP_MODE), .COPY_ON_SWAP(1)) dut (
    .clk(clk), .rst(rst), .we_a(we_a), .sel_a(sel_a), .adr_a(adr_a), .dat_a(dat_a),
    .ack_a(ack_a), .busy_a(busy_a), .commit(commit), .frame_done_b(frame_done_b),
    .adr_b(adr_b), .dat_b(dat_b), .swap_pending(swap_pending), .front_bank(front_bank)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  bit [DW-1:0] m [2][DEPTH];
  bit          mack, mbusy, mpend, mfront, macc, msw, mpre, mrv;
  bit [DW-1:0] mdatb;
  int          mstep;

  // Reference model: applies each cycle's rules to whole-bank arrays
  always @(posedge clk) begin
    if (rst) begin
      mack = 1'b0; mbusy = 1'b0; mpend = 1'b0; mfront = 1'b0; mdatb = '0; mstep = 0;
    end else begin
      mdatb = m[mfront][adr_b];
      mpre  = mbusy;
      macc  = we_a && !mbusy && !mack;
      if (macc) begin
        mrv = (SWAP_MODE == 2) || (SWAP_MODE == 1 && adr_a[0] == 1'b0);
        for (int i = 0; i < NB; i++) begin
          int d;
          d = mrv ? (NB - 1 - i) : i;
          if (sel_a[i]) m[~mfront][adr_a][8*d +: 8] = dat_a[8*i +: 8];
        end
      end
      if (mbusy) begin
        if (mstep > 0) m[~mfront][mstep-1] = m[mfront][mstep-1];
        mstep++;
        if (mstep == DEPTH + 1) mbusy = 1'b0;
      end
      msw = frame_done_b && (mpend || commit) && !mpre;
      if (msw) begin
        mfront = ~mfront; mpend = 1'b0; mbusy = 1'b1; mstep = 0;
      end else if (commit) begin
        mpend = 1'b1;
      end
      mack = macc;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  bit datb_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: inputs already applied, compare DUT outputs to the model mid-cycle
  task automatic cyc();
    @(negedge clk);
    chk("ack_a", 32'(ack_a), 32'(mack));
    chk("busy_a", 32'(busy_a), 32'(mbusy));
    chk("swap_pending", 32'(swap_pending), 32'(mpend));
    chk("front_bank", 32'(front_bank), 32'(mfront));
    if (datb_en) chk("dat_b", 32'(dat_b), 32'(mdatb));
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] s);
    bit got;
    got = 1'b0;
    we_a = 1'b1; adr_a = a; dat_a = d; sel_a = s;
    for (int i = 0; i < 600 && !got; i++) begin
      cyc();
      got = ack_a;
    end
    we_a = 1'b0;
    chk("wr_ack_seen", 32'(got), 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 600 && busy_a; i++) cyc();
    chk("idle_reached", 32'(busy_a), 32'd0);
  endtask

  task automatic swap_now();
    commit = 1'b1; frame_done_b = 1'b1;
    cyc();
    commit = 1'b0; frame_done_b = 1'b0;
  endtask

  initial begin
    int pc, bc, ac;
    // Reset state
    rst = 1'b1;
    cyc(); cyc();
    chk("rst_ack", 32'(ack_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_pend", 32'(swap_pending), 32'd0);
    chk("rst_front", 32'(front_bank), 32'd0);
    chk("rst_datb", 32'(dat_b), 32'd0);
    rst = 1'b0;

    // Bring both banks to a known zero image
    for (int a = 0; a < DEPTH; a++) wr(AW'(a), '0, '1);
    swap_now();
    wait_idle();
    datb_en = 1'b1;
    chk("init_front", 32'(front_bank), 32'd1);

    // Even address byte-reversed, odd address straight
    wr(8'd0, 16'h1234, 2'b11);
    wr(8'd1, 16'h1234, 2'b11);
    swap_now();
    chk("swap1_front", 32'(front_bank), 32'd0);
    adr_b = 8'd0; cyc(); chk("rev_even", 32'(dat_b), 32'h3412);
    adr_b = 8'd1; cyc(); chk("rev_odd", 32'(dat_b), 32'h1234);

    // Partial lane writes follow the reversed enables
    wr(8'd2, 16'hABCD, 2'b01);
    wr(8'd3, 16'hABCD, 2'b01);
    swap_now();
    adr_b = 8'd2; cyc(); chk("lane_even", 32'(dat_b), 32'hCD00);
    adr_b = 8'd3; cyc(); chk("lane_odd", 32'(dat_b), 32'h00CD);
    wait_idle();

    // Request held until acknowledge: one write, one ack
    ac = 0;
    we_a = 1'b1; adr_a = 8'd9; dat_a = 16'h0F0F; sel_a = 2'b11;
    cyc(); ac += int'(ack_a);
    we_a = 1'b0;
    cyc(); ac += int'(ack_a);
    cyc(); ac += int'(ack_a);
    chk("single_ack", 32'(ac), 32'd1);

    // Commit then boundary five cycles later, copy duration
    pc = 0;
    commit = 1'b1; cyc(); pc += int'(swap_pending); commit = 1'b0;
    repeat (4) begin cyc(); pc += int'(swap_pending); end
    frame_done_b = 1'b1; cyc(); pc += int'(swap_pending); frame_done_b = 1'b0;
    chk("pend_cycles", 32'(pc), 32'd5);
    chk("swap3_front", 32'(front_bank), 32'd0);
    bc = int'(busy_a);
    for (int i = 0; i < 400 && busy_a; i++) begin cyc(); bc += int'(busy_a); end
    chk("busy_cycles", 32'(bc), 32'd257);

    // Write accepted in the swap cycle lands in the new front
    we_a = 1'b1; adr_a = 8'd5; dat_a = 16'h5A5A; sel_a = 2'b11;
    commit = 1'b1; frame_done_b = 1'b1;
    cyc();
    we_a = 1'b0; commit = 1'b0; frame_done_b = 1'b0;
    chk("swapw_ack", 32'(ack_a), 32'd1);
    chk("swapw_front", 32'(front_bank), 32'd1);
    adr_b = 8'd5; cyc(); chk("swapw_data", 32'(dat_b), 32'h5A5A);

    // Reset in the middle of a copy
    repeat (98) cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("abort_busy", 32'(busy_a), 32'd0);
    chk("abort_front", 32'(front_bank), 32'd0);
    chk("abort_pend", 32'(swap_pending), 32'd0);
    chk("abort_datb", 32'(dat_b), 32'd0);
    wr(8'd7, 16'h7777, 2'b11);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      we_a         = ($urandom_range(0, 1) == 0);
      sel_a        = NB'($urandom);
      adr_a        = AW'($urandom);
      dat_a        = DW'($urandom);
      adr_b        = AW'($urandom);
      commit       = ($urandom_range(0, 19) == 0);
      frame_done_b = ($urandom_range(0, 9) == 0);
      rst          = ($urandom_range(0, 599) == 0);
      cyc();
    end
    rst = 1'b0; we_a = 1'b0; commit = 1'b0; frame_done_b = 1'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
